seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: glyph table, segment bit positions and scan states shared by the seg_scan_ctrl slice
package seg_pkg;
   localparam int SEG_DP = 7;
   localparam logic [3:0] HEX_FIRST = 4'd10;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;
   localparam logic [15:0][6:0] GLYPH_TAB = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };
   typedef enum logic {IDLE, RUN} scan_state_t;
endpackage

// File: rtl/seg_decode.sv
// seg_decode: nibble to active-high {g..a} glyph, hex letters only when hex_mode is set
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   input  logic       blank,
   output logic [6:0] seg
);
   always_comb seg = (blank || (!hex_mode && nibble >= HEX_FIRST)) ? GLYPH_BLANK : GLYPH_TAB[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with frame shadowing, zero blanking and PWM dimming
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int BANKS  = 2,
   parameter int DIGITS = 4,
   parameter int DIV    = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*BANKS*DIGITS-1:0] digits,
   input  logic [BANKS*DIGITS-1:0]   dp_mask,
   input  logic                      hex_mode,
   input  logic                      lz_suppress,
   input  logic [3:0]                brightness,
   output logic [8*BANKS-1:0]        segs,
   output logic [DIGITS*BANKS-1:0]   en,
   output logic                      frame_done
);
   localparam int CW = $clog2(DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
   scan_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [4*BANKS*DIGITS-1:0] sh_d, sh_d_nxt;
   logic [BANKS*DIGITS-1:0] sh_dp, sh_dp_nxt;
   logic [8*BANKS-1:0] segs_nxt;
   logic [DIGITS*BANKS-1:0] en_nxt;
   logic tick, load, on, fd_nxt;
   logic [31:0] thr;
   // Outputs are built from next-cycle values so they change on the tick edge itself
   always_comb begin
      tick      = cnt == CNT_MAX;
      cnt_nxt   = tick ? '0 : cnt + CW'(1);
      load      = tick && (state == IDLE || idx == IDX_MAX);
      fd_nxt    = tick && state == RUN && idx == IDX_MAX;
      state_nxt = tick ? RUN : state;
      idx_nxt   = !tick ? idx : load ? '0 : idx + IW'(1);
      sh_d_nxt  = load ? digits : sh_d;
      sh_dp_nxt = load ? dp_mask : sh_dp;
      thr       = ((32'(brightness) + 32'd1) * 32'(DIV)) >> 4;
      on        = state_nxt == RUN && 32'(cnt_nxt) < thr;
   end
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [3:0] nib;
      logic       lead;
      logic       dp;
      logic [6:0] glyph;
      logic [7:0] row;
      int         pos;
      // lead: this digit and everything above it in the bank are zero
      always_comb begin
         pos  = DIGITS - 1 - int'(idx_nxt);
         nib  = sh_d_nxt[4*(b*DIGITS+pos) +: 4];
         dp   = sh_dp_nxt[b*DIGITS+pos];
         lead = pos != 0;
         for (int k = 0; k < DIGITS; k++)
            if (k >= pos && sh_d_nxt[4*(b*DIGITS+k) +: 4] != 4'd0) lead = 1'b0;
      end
      always_comb begin
         row         = {1'b0, glyph};
         row[SEG_DP] = dp;
      end
      seg_decode u_dec (.nibble(nib), .hex_mode(hex_mode), .blank(lz_suppress && lead), .seg(glyph));
      assign segs_nxt[8*b +: 8]          = state_nxt == RUN ? row : '0;
      assign en_nxt[DIGITS*b +: DIGITS] = on ? DIGITS'(1) << idx_nxt : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         sh_d       <= '0;
         sh_dp      <= '0;
         segs       <= '0;
         en         <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         sh_d       <= sh_d_nxt;
         sh_dp      <= sh_dp_nxt;
         segs       <= segs_nxt;
         en         <= en_nxt;
         frame_done <= fd_nxt;
      end
endmodule
